// File: rtl/nrzi_unstuff_decoder.sv
// nrzi_unstuff_decoder
//   USB receive-path NRZI decoder with integrated bit unstuffing. The line is
//   sampled on each shift_enable strobe. A decoded bit is 1 when the line level
//   did not change from the previous bit period, and 0 when it did. After
//   STUFF_LEN consecutive decoded 1s the next bit must be a stuffed 0. That bit
//   is dropped; a 1 in that position raises stuff_err.
//
// Parameters
//   STUFF_LEN   run of decoded 1s after which a stuffed 0 is required
//   IDLE_LEVEL  line level (1=J, 0=K) held in the history register at reset/EOP
//
// Ports
//   clk           system clock
//   n_rst         asynchronous active-low reset
//   d_plus        synchronised D+ line
//   d_minus       synchronised D- line
//   shift_enable  one-cycle sample strobe, once per bit period
//   eop           end-of-packet indication; has priority over data decoding
//   d_orig        registered decoded data bit
//   bit_valid     one-cycle pulse: d_orig holds a new payload bit
//   stuff_err     one-cycle pulse: a 1 arrived where a stuffed 0 was required
//   se0           registered: the last sample was SE0
//   line_err      one-cycle pulse on an SE1 sample (NRZI_SE1_DETECT_EN only)
//
// Configuration
//   NRZI_SE1_DETECT_EN  when defined, an SE1 sample pulses line_err, clears the
//                       run counter and holds the line history. When undefined,
//                       SE1 holds the line level and therefore decodes as a 1.

module nrzi_unstuff_decoder #(
  parameter int unsigned STUFF_LEN  = 6,
  parameter bit          IDLE_LEVEL = 1'b1
) (
  input  logic clk,
  input  logic n_rst,
  input  logic d_plus,
  input  logic d_minus,
  input  logic shift_enable,
  input  logic eop,
  output logic d_orig,
  output logic bit_valid,
  output logic stuff_err,
  output logic se0,
  output logic line_err
);

  localparam int unsigned CntW   = $clog2(STUFF_LEN + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STUFF_LEN);

  logic            prev_level_q, prev_level_d;
  logic [CntW-1:0] ones_cnt_q, ones_cnt_d;
  logic            d_orig_d, bit_valid_d, stuff_err_d, se0_d, line_err_d;

  logic is_j, is_k, is_se0, se1_hit;
  logic line_bit, decoded;

`ifdef NRZI_SE1_DETECT_EN
  assign se1_hit = d_plus & d_minus;
`else
  assign se1_hit = 1'b0;
`endif

  // Line decode: SE0/SE1 hold the previous level, so they decode as a 1.
  always_comb begin
    is_j     = d_plus & ~d_minus;
    is_k     = ~d_plus & d_minus;
    is_se0   = ~d_plus & ~d_minus;
    line_bit = is_j ? 1'b1 : (is_k ? 1'b0 : prev_level_q);
    decoded  = (line_bit == prev_level_q);
  end

  always_comb begin
    prev_level_d = prev_level_q;
    ones_cnt_d   = ones_cnt_q;
    d_orig_d     = d_orig;
    se0_d        = se0;
    // Pulses clear in every cycle unless a strobe sets them.
    bit_valid_d  = 1'b0;
    stuff_err_d  = 1'b0;
    line_err_d   = 1'b0;

    if (shift_enable) begin
      se0_d = is_se0;
      if (eop) begin
        prev_level_d = IDLE_LEVEL;
        ones_cnt_d   = '0;
      end else if (se1_hit) begin
        line_err_d = 1'b1;
        ones_cnt_d = '0;
      end else if (ones_cnt_q < CntMax) begin
        d_orig_d     = decoded;
        bit_valid_d  = 1'b1;
        prev_level_d = line_bit;
        ones_cnt_d   = decoded ? ones_cnt_q + CntW'(1) : '0;
      end else begin
        // Stuff position: a 0 is dropped silently, a 1 is a protocol error.
        stuff_err_d  = decoded;
        prev_level_d = line_bit;
        ones_cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      prev_level_q <= IDLE_LEVEL;
      ones_cnt_q   <= '0;
      d_orig       <= 1'b1;
      bit_valid    <= 1'b0;
      stuff_err    <= 1'b0;
      se0          <= 1'b0;
      line_err     <= 1'b0;
    end else begin
      prev_level_q <= prev_level_d;
      ones_cnt_q   <= ones_cnt_d;
      d_orig       <= d_orig_d;
      bit_valid    <= bit_valid_d;
      stuff_err    <= stuff_err_d;
      se0          <= se0_d;
      line_err     <= line_err_d;
    end
  end

endmodule
